// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, field helpers and the divider state set.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORM,
        ROUND,
        DONE
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/divider_if.sv
// Operand/result bus shared by the accelerator's floating-point units.
interface divider_if;

    logic        input_valid;
    logic        input_ready;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        output_valid;
    logic [31:0] output_z;

    modport master (
        output input_valid, input_a, input_b,
        input  input_ready, output_valid, output_z
    );

    modport slave (
        input  input_valid, input_a, input_b,
        output input_ready, output_valid, output_z
    );

endinterface

// File: rtl/fp_div_mant.sv
// Radix-2 restoring divider for 24-bit significands, one quotient bit per clock.
module fp_div_mant #(
    parameter int QBITS = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      mant_a,
    input  logic [23:0]      mant_b,
    output logic             done,
    output logic [QBITS-1:0] q,
    output logic             sticky
);

    logic [24:0] rem;
    logic [4:0]  cnt;
    logic        busy;
    logic [25:0] trial;
    logic        trial_ok;
    logic [24:0] rem_keep;

    // rem stays below 2*mant_b, so a set bit 25 of the difference means it went negative.
    assign trial    = {1'b0, rem} - {2'b00, mant_b};
    assign trial_ok = ~trial[25];
    assign rem_keep = trial_ok ? trial[24:0] : rem;
    assign done     = busy && (cnt == 5'(QBITS - 1));
    assign sticky   = (rem != 25'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            q    <= '0;
        end else if (start) begin
            rem  <= {1'b0, mant_a};
            cnt  <= '0;
            busy <= 1'b1;
            q    <= '0;
        end else if (busy) begin
            q    <= {q[QBITS-2:0], trial_ok};
            rem  <= {rem_keep[23:0], 1'b0};
            cnt  <= cnt + 5'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/divider.sv
// IEEE-754 single-precision divider: special-case resolution, iterative mantissa
// division, single-step normalisation and round-to-nearest-even.
module divider
    import fp_pkg::*;
#(
    parameter int QBITS    = 26,
    parameter int FLUSH_DN = 1
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);

    state_t state, next_state;

    logic [31:0]       a_reg, b_reg;
    logic              sign_z;
    logic signed [9:0] exp_z;
    logic [QBITS-1:0]  q_n;
    logic              sticky_n;
    logic [31:0]       res_z;
    logic [31:0]       out_z;
    logic              out_valid;
    logic              ready;
    logic              start;

    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              sign_u, special;
    logic [31:0]       special_z;
    logic [9:0]        exp_u;

    logic              div_done, div_sticky;
    logic [QBITS-1:0]  div_q;

    logic [23:0]       mant;
    logic              guard, round_sticky, inc;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [22:0]       mant_f;
    logic [31:0]       round_z;

    assign ea = fp_exp(a_reg);
    assign eb = fp_exp(b_reg);
    assign fa = fp_frac(a_reg);
    assign fb = fp_frac(b_reg);

    // Denormals count as zero when flushing; otherwise only true zeros do.
    assign a_zero  = (ea == 8'd0) && ((FLUSH_DN != 0) || (fa == 23'd0));
    assign b_zero  = (eb == 8'd0) && ((FLUSH_DN != 0) || (fb == 23'd0));
    assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    assign sign_u  = fp_sign(a_reg) ^ fp_sign(b_reg);
    assign special = a_nan | b_nan | a_zero | b_zero | a_inf | b_inf;
    assign exp_u   = {2'b00, ea} - {2'b00, eb} + 10'(EXP_BIAS);

    always_comb begin
        special_z = {sign_u, 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_z = QNAN;
        end else if (a_inf || b_zero) begin
            special_z = {sign_u, POS_INF[30:0]};
        end
    end

    fp_div_mant #(.QBITS(QBITS)) u_mant (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mant_a ({ea != 8'd0, fa}),
        .mant_b ({eb != 8'd0, fb}),
        .done   (div_done),
        .q      (div_q),
        .sticky (div_sticky)
    );

    assign mant         = q_n[QBITS-1 -: 24];
    assign guard        = q_n[QBITS-25];
    assign round_sticky = (|q_n[QBITS-26:0]) | sticky_n;
    assign inc          = guard && (round_sticky || mant[0]);
    assign mant_r       = {1'b0, mant} + 25'(inc);
    assign exp_r        = mant_r[24] ? exp_z + 10'sd1 : exp_z;
    assign mant_f       = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    always_comb begin
        round_z = {sign_z, exp_r[7:0], mant_f};
        if (exp_r >= $signed(10'(EXP_MAX))) begin
            round_z = {sign_z, POS_INF[30:0]};
        end else if (exp_r <= 10'sd0) begin
            round_z = {sign_z, 31'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.input_valid) begin
                    next_state = UNPACK;
                end
            end
            UNPACK: begin
                if (special) begin
                    next_state = DONE;
                end else begin
                    start      = 1'b1;
                    next_state = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    next_state = NORM;
                end
            end
            NORM:    next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The result register is loaded while leaving DONE, so the pulse lands in the following IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sign_z    <= 1'b0;
            exp_z     <= '0;
            q_n       <= '0;
            sticky_n  <= 1'b0;
            res_z     <= '0;
            out_z     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.input_valid) begin
                        a_reg <= bus.input_a;
                        b_reg <= bus.input_b;
                    end
                end
                UNPACK: begin
                    sign_z <= sign_u;
                    exp_z  <= signed'(exp_u);
                    if (special) begin
                        res_z <= special_z;
                    end
                end
                NORM: begin
                    sticky_n <= div_sticky;
                    if (div_q[QBITS-1]) begin
                        q_n <= div_q;
                    end else begin
                        q_n   <= {div_q[QBITS-2:0], 1'b0};
                        exp_z <= exp_z - 10'sd1;
                    end
                end
                ROUND: begin
                    res_z <= round_z;
                end
                DONE: begin
                    out_z     <= res_z;
                    out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.input_ready  = ready;
    assign bus.output_valid = out_valid;
    assign bus.output_z     = out_z;

endmodule
